// File: rtl/imm_gen_fifo.sv
// RV32/RV64 immediate generator feeding a DEPTH-entry tagged FIFO.
// Decode is on the input side; only the decoded immediate, tag and illegal flag are stored.
module imm_gen_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      InstrIn,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] TagIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  SignImm,
  output logic [TAG_W-1:0] TagOut,
  output logic             IllegalImm,
  output logic [7:0]       IllegalCnt,
  input  logic             ClrCnt
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic             ill_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;
  logic             push, pop;

  // Size casts of signed fields give the sign extension from instr[31].
  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    case (ImmSrc)
      3'b000:  dec_imm = XLEN'($signed(InstrIn[31:20]));
      3'b001:  dec_imm = XLEN'($signed({InstrIn[31:25], InstrIn[11:7]}));
      3'b010:  dec_imm = XLEN'($signed({InstrIn[31], InstrIn[7], InstrIn[30:25],
                                         InstrIn[11:8], 1'b0}));
      3'b011:  dec_imm = XLEN'($signed({InstrIn[31:12], 12'b0}));
      3'b100:  dec_imm = XLEN'($signed({InstrIn[31], InstrIn[19:12], InstrIn[20],
                                         InstrIn[30:21], 1'b0}));
      default: dec_ill = 1'b1;
    endcase
  end

  assign InReady  = (occ_q != (AW+1)'(DEPTH));
  assign OutValid = (occ_q != '0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;

  assign SignImm    = imm_q[rd_ptr_q];
  assign TagOut     = tag_q[rd_ptr_q];
  assign IllegalImm = ill_q[rd_ptr_q];
  assign IllegalCnt = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      occ_d = occ_q + (AW+1)'(1);
    else if (!push && pop) occ_d = occ_q - (AW+1)'(1);
    // Clear wins over a coincident illegal push.
    if (ClrCnt)                                  cnt_d = '0;
    else if (push && dec_ill && cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_q[i] <= '0;
        tag_q[i] <= '0;
        ill_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      if (push) begin
        imm_q[wr_ptr_q] <= dec_imm;
        tag_q[wr_ptr_q] <= TagIn;
        ill_q[wr_ptr_q] <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_fifo.sv
// Directed bench for imm_gen_fifo: decode at XLEN 32/64, fill/drain, illegal counter, reset.
module tb_imm_gen_fifo;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        InValid = 1'b0, OutReady = 1'b0, ClrCnt = 1'b0;
  logic [31:0] InstrIn = '0;
  logic [2:0]  ImmSrc = '0;
  logic [4:0]  TagIn = '0;
  logic        InReady, OutValid, IllegalImm;
  logic [31:0] SignImm;
  logic [4:0]  TagOut;
  logic [7:0]  IllegalCnt;

  logic        v64 = 1'b0, or64 = 1'b1;
  logic        InReady64, OutValid64, IllegalImm64;
  logic [63:0] SignImm64;
  logic [4:0]  TagOut64;
  logic [7:0]  IllegalCnt64;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  imm_gen_fifo #(.XLEN(32), .DEPTH(4), .TAG_W(5)) dut (
    .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady), .InstrIn(InstrIn),
    .ImmSrc(ImmSrc), .TagIn(TagIn), .OutValid(OutValid), .OutReady(OutReady),
    .SignImm(SignImm), .TagOut(TagOut), .IllegalImm(IllegalImm),
    .IllegalCnt(IllegalCnt), .ClrCnt(ClrCnt)
  );

  imm_gen_fifo #(.XLEN(64), .DEPTH(4), .TAG_W(5)) dut64 (
    .CLK(CLK), .RST(RST), .InValid(v64), .InReady(InReady64), .InstrIn(InstrIn),
    .ImmSrc(ImmSrc), .TagIn(TagIn), .OutValid(OutValid64), .OutReady(or64),
    .SignImm(SignImm64), .TagOut(TagOut64), .IllegalImm(IllegalImm64),
    .IllegalCnt(IllegalCnt64), .ClrCnt(ClrCnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] dec_instr [5];
  logic [31:0] dec_exp32 [5];
  logic [63:0] dec_exp64 [5];

  initial begin
    dec_instr = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h800000B7, 32'h0010006F};
    dec_exp32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000, 32'h00000800};
    dec_exp64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                  64'hFFFFFFFF80000000, 64'h0000000000000800};

    // Reset state
    tick(); tick();
    chk("rst_outvalid", 64'(OutValid), 64'd0);
    chk("rst_inready", 64'(InReady), 64'd1);
    chk("rst_signimm", 64'(SignImm), 64'd0);
    chk("rst_tagout", 64'(TagOut), 64'd0);
    chk("rst_illegal", 64'(IllegalImm), 64'd0);
    chk("rst_cnt", 64'(IllegalCnt), 64'd0);
    RST = 1'b0;

    // One push per format, checked at the head of both widths
    OutReady = 1'b1;
    for (int f = 0; f < 5; f++) begin
      InstrIn = dec_instr[f]; ImmSrc = 3'(f); TagIn = 5'(f + 1);
      InValid = 1'b1; v64 = 1'b1;
      tick();
      InValid = 1'b0; v64 = 1'b0;
      chk($sformatf("dec32_valid_%0d", f), 64'(OutValid), 64'd1);
      chk($sformatf("dec32_imm_%0d", f), 64'(SignImm), 64'(dec_exp32[f]));
      chk($sformatf("dec32_tag_%0d", f), 64'(TagOut), 64'(f + 1));
      chk($sformatf("dec64_imm_%0d", f), SignImm64, dec_exp64[f]);
      tick();
    end
    chk("dec_drained", 64'(OutValid), 64'd0);
    chk("dec_cnt_zero", 64'(IllegalCnt), 64'd0);

    // Fill with tags 1..5 while the consumer stalls
    OutReady = 1'b0; ImmSrc = 3'b000; InstrIn = 32'h00100093;
    for (int t = 1; t <= 4; t++) begin
      TagIn = 5'(t); InValid = 1'b1;
      tick();
      chk($sformatf("fill_inready_%0d", t), 64'(InReady), (t == 4) ? 64'd0 : 64'd1);
    end
    TagIn = 5'd5;
    tick();
    chk("full_hold_inready", 64'(InReady), 64'd0);
    chk("full_head_tag", 64'(TagOut), 64'd1);
    OutReady = 1'b1;
    tick();
    chk("drain_tag2", 64'(TagOut), 64'd2);
    chk("drain_inready", 64'(InReady), 64'd1);
    tick();
    InValid = 1'b0;
    chk("drain_tag3", 64'(TagOut), 64'd3);
    tick();
    chk("drain_tag4", 64'(TagOut), 64'd4);
    tick();
    chk("drain_tag5", 64'(TagOut), 64'd5);
    chk("drain_imm5", 64'(SignImm), 64'd1);
    tick();
    chk("drain_empty", 64'(OutValid), 64'd0);

    // Illegal format
    ImmSrc = 3'b110; InstrIn = 32'hFFFFFFFF; TagIn = 5'd7; InValid = 1'b1;
    tick();
    InValid = 1'b0;
    chk("ill_imm", 64'(SignImm), 64'd0);
    chk("ill_flag", 64'(IllegalImm), 64'd1);
    chk("ill_tag", 64'(TagOut), 64'd7);
    chk("ill_cnt1", 64'(IllegalCnt), 64'd1);
    tick();
    InValid = 1'b1;
    for (int i = 0; i < 253; i++) tick();
    chk("ill_cnt254", 64'(IllegalCnt), 64'd254);
    for (int i = 0; i < 46; i++) tick();
    InValid = 1'b0;
    chk("ill_cnt_sat", 64'(IllegalCnt), 64'd255);
    InValid = 1'b1; ClrCnt = 1'b1;
    tick();
    ClrCnt = 1'b0;
    chk("ill_clr_prio", 64'(IllegalCnt), 64'd0);
    tick();
    InValid = 1'b0;
    chk("ill_after_clr", 64'(IllegalCnt), 64'd1);
    tick(); tick();
    chk("ill_drained", 64'(OutValid), 64'd0);

    // Steady push+pop at occupancy 2; immediate equals tag
    OutReady = 1'b0; ImmSrc = 3'b000; InValid = 1'b1;
    for (int t = 10; t <= 11; t++) begin
      TagIn = 5'(t); InstrIn = 32'(t) << 20;
      tick();
    end
    OutReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      TagIn = 5'(12 + i); InstrIn = 32'(12 + i) << 20;
      tick();
      chk($sformatf("stream_tag_%0d", i), 64'(TagOut), 64'(11 + i));
      chk($sformatf("stream_imm_%0d", i), 64'(SignImm), 64'(11 + i));
      chk($sformatf("stream_rdy_%0d", i), 64'(InReady), 64'd1);
    end
    OutReady = 1'b0;
    TagIn = 5'd1; InstrIn = 32'h00100093;
    tick();
    InValid = 1'b0;
    chk("pre_rst_cnt", 64'(IllegalCnt), 64'd1);

    // Asynchronous reset between edges with 3 entries queued
    #2 RST = 1'b1;
    #1;
    chk("arst_outvalid", 64'(OutValid), 64'd0);
    chk("arst_cnt", 64'(IllegalCnt), 64'd0);
    chk("arst_inready", 64'(InReady), 64'd1);
    #1 RST = 1'b0;
    TagIn = 5'd9; InstrIn = 32'hFFF00093; ImmSrc = 3'b000; InValid = 1'b1;
    chk("post_rst_empty", 64'(OutValid), 64'd0);
    tick();
    InValid = 1'b0;
    chk("post_rst_valid", 64'(OutValid), 64'd1);
    chk("post_rst_tag", 64'(TagOut), 64'd9);
    chk("post_rst_imm", 64'(SignImm), 64'hFFFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
